serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/alu_pkg.sv | 14 +
 rtl/fulladder.sv | 14 +
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
// Holds the FSM state encoding and the default operand width.
package alu_pkg;

    // IDLE accepts work, RUN shifts one bit per clock, DONE presents results.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell used by the serial arithmetic datapath.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one full adder, one bit per clock.
// Ports: clk, rst (async, active-high), start/sub/a/b in;
// ready, done, s, cout, ovf, zero out (results registered).
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic fa_s;
    logic fa_cout;

    fulladder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .cout (fa_cout),
        .s    (fa_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b, seed carry with 1.
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {fa_s, r_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // On the MSB step carry_q is the carry into the MSB.
                    state_d = DONE;
                    s_d     = r_sh_d;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    zero_d  = (r_sh_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign s     = s_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4).
// Compares DUT results against an arithmetic reference model.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int pass_cnt = 0;
    int total    = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Reference: {s, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [W+2:0] model(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         sb
    );
        int ux, uy, sx, sy, r, sr;
        logic c, o, z;
        logic [W-1:0] res;
        ux = int'(x);
        uy = int'(y);
        sx = ux - ((ux >= (1 << (W - 1))) ? (1 << W) : 0);
        sy = uy - ((uy >= (1 << (W - 1))) ? (1 << W) : 0);
        if (sb) begin
            r  = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            r  = ux + uy;
            sr = sx + sy;
            c  = (r >= (1 << W));
        end
        o   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        res = W'(r & ((1 << W) - 1));
        z   = (res == '0);
        return {res, c, o, z};
    endfunction

    // Issue one operation from IDLE; scrambles inputs while busy.
    task automatic run_op(
        input  logic [W-1:0] ia,
        input  logic [W-1:0] ib,
        input  logic         isub,
        output int           lat,
        output logic [W+2:0] got,
        output bit           rdy_ok
    );
        lat    = -1;
        rdy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = isub;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) rdy_ok = 1'b0;
            if (done) begin
                lat   = n;
                start = 1'b0;
                break;
            end
            start = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom);
        end
        start = 1'b0;
        got   = {s, cout, ovf, zero};
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        total++;
        if ({ready, done, s, cout, ovf, zero} !== {1'b1, 1'b0, 7'b0})
            $display("FAIL reset_state got=%b exp=%b",
                     {ready, done, s, cout, ovf, zero}, {1'b1, 1'b0, 7'b0});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vs [6];
        logic [W+2:0] exp_t [6];
        logic [W+2:0] got;
        int lat;
        bit rok;
        va = '{4'b0011, 4'b1111, 4'b0011, 4'b1000, 4'b0101, 4'b0000};
        vb = '{4'b0101, 4'b0001, 4'b0101, 4'b0001, 4'b0011, 4'b0000};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_t = '{7'b1000_0_1_0, 7'b0000_1_0_1, 7'b1110_0_0_0,
                  7'b0111_1_1_0, 7'b0010_1_0_0, 7'b0000_1_0_1};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], lat, got, rok);
            total++;
            if (got !== exp_t[i])
                $display("FAIL directed_%0d got=%b exp=%b", i, got, exp_t[i]);
            else pass_cnt++;
            total++;
            if (lat !== W + 1 || !rok)
                $display("FAIL latency_%0d got=%0d rdy_ok=%0d exp=%0d",
                         i, lat, rok, W + 1);
            else pass_cnt++;
        end
    endtask

    // Results must hold while the next operation is in flight.
    task automatic test_hold;
        logic [W+2:0] prev;
        prev = model(4'b0110, 4'b0111, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b0110;
        b     = 4'b0111;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < W + 2; n++) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b0001;
        b     = 4'b0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({s, cout, ovf, zero} !== prev)
            $display("FAIL hold got=%b exp=%b", {s, cout, ovf, zero}, prev);
        else pass_cnt++;
        for (int n = 0; n < W + 2; n++) @(negedge clk);
    endtask

    // start held high, operands change every cycle.
    task automatic test_back_to_back;
        logic [W-1:0] ha [40];
        logic [W-1:0] hb [40];
        logic         hs [40];
        logic [W+2:0] e;
        bit exp_done;
        int bad;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            ha[c] = W'($urandom);
            hb[c] = W'($urandom);
            hs[c] = 1'($urandom);
            start = 1'b1;
            a     = ha[c];
            b     = hb[c];
            sub   = hs[c];
            @(negedge clk);
            exp_done = ((c % (W + 2)) == W);
            total++;
            if (done !== exp_done) begin
                $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, exp_done);
                bad++;
            end else pass_cnt++;
            if (exp_done) begin
                e = model(ha[c-W], hb[c-W], hs[c-W]);
                total++;
                if ({s, cout, ovf, zero} !== e)
                    $display("FAIL b2b_result c=%0d got=%b exp=%b",
                             c, {s, cout, ovf, zero}, e);
                else pass_cnt++;
            end
        end
        start = 1'b0;
        for (int n = 0; n < W + 2; n++) @(negedge clk);
        if (bad != 0) $display("b2b done errors: %0d", bad);
    endtask

    task automatic test_reset_abort;
        logic [W+2:0] got;
        int lat;
        bit rok;
        bit saw_done;
        @(negedge clk);
        start = 1'b1;
        a     = 4'b0111;
        b     = 4'b0111;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({ready, done, s, cout, ovf, zero} !== {1'b1, 1'b0, 7'b0})
            $display("FAIL abort_state got=%b exp=%b",
                     {ready, done, s, cout, ovf, zero}, {1'b1, 1'b0, 7'b0});
        else pass_cnt++;
        @(negedge clk);
        rst      = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < W + 3; n++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0)
            $display("FAIL abort_no_done got=%b exp=0", saw_done);
        else pass_cnt++;
        run_op(4'b0001, 4'b0001, 1'b0, lat, got, rok);
        total++;
        if (got !== 7'b0010_0_0_0 || lat !== W + 1)
            $display("FAIL abort_recover got=%b lat=%0d exp=%b lat=%0d",
                     got, lat, 7'b0010_0_0_0, W + 1);
        else pass_cnt++;
    endtask

    task automatic test_exhaustive;
        logic [W+2:0] got;
        logic [W+2:0] e;
        int lat;
        bit rok;
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < (1 << W); x++)
                for (int y = 0; y < (1 << W); y++) begin
                    run_op(W'(x), W'(y), 1'(m), lat, got, rok);
                    e = model(W'(x), W'(y), 1'(m));
                    total++;
                    if (got !== e || lat !== W + 1 || !rok)
                        $display("FAIL exh sub=%0d a=%0d b=%0d got=%b lat=%0d exp=%b",
                                 m, x, y, got, lat, e);
                    else pass_cnt++;
                end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
